// File: rtl/carrier_sync_controller.sv
`default_nettype none
// ============================================================================
// Module      : carrier_sync_controller
// Description : Sequences the peak detector through acquisition, lock and
//               loss-of-lock recovery. Latches the detector offset for the
//               demodulator and, while locked, checks that peaks keep
//               arriving at the phases the offset predicts.
//               Optional build macro CARRIER_SYNC_STATS_EN adds the
//               miss_total output (saturating count of missed periods).
// Revision    : 1.0 - initial release
// ============================================================================
module carrier_sync_controller #(
    parameter int DATA_WIDTH     = 8,
    parameter int WAVELENGTH     = 40,
    parameter int THRESHOLD      = 150,
    parameter int MISS_LIMIT     = 3,
    parameter int ACQ_TIMEOUT    = 100,
    parameter int HOLDOFF_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] signal,
    input  logic [15:0]           phase,
    input  logic                  det_ready,
    input  logic [15:0]           det_offset,
    output logic                  det_clear,
    output logic [15:0]           offset,
    output logic                  locked,
    output logic [1:0]            state,
    output logic [7:0]            relock_count,
    output logic                  acq_timeout
`ifdef CARRIER_SYNC_STATS_EN
    ,
    output logic [15:0]           miss_total
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    localparam logic [16:0] c_WAVE17     = 17'(WAVELENGTH);
    localparam logic [16:0] c_QTR        = 17'(WAVELENGTH / 4);
    localparam logic [16:0] c_THREE_QTR  = 17'((3 * WAVELENGTH) / 4);
    localparam logic [15:0] c_WAVE16     = 16'(WAVELENGTH);
    localparam logic [15:0] c_ACQ_LAST   = 16'(ACQ_TIMEOUT - 1);
    localparam logic [15:0] c_HOLD_LAST  = 16'(HOLDOFF_CYCLES - 1);
    localparam logic [15:0] c_MISS_LIMIT = 16'(MISS_LIMIT);
    localparam logic [31:0] c_THRESH     = 32'(THRESHOLD);

    state_t      r_state;
    logic        r_det_clear;
    logic [15:0] r_offset;
    logic        r_locked;
    logic [7:0]  r_relock;
    logic        r_acq_to;
    logic [15:0] r_timer;
    logic [15:0] r_holdoff;
    logic [15:0] r_miss;
    logic        r_hit;

    state_t      w_state_nxt;
    logic        w_det_clear_nxt;
    logic [15:0] w_offset_nxt;
    logic        w_locked_nxt;
    logic [7:0]  w_relock_nxt;
    logic        w_acq_to_nxt;
    logic [15:0] w_timer_nxt;
    logic [15:0] w_holdoff_nxt;
    logic [15:0] w_miss_nxt;
    logic        w_hit_nxt;

    logic [16:0] w_sum0;
    logic [16:0] w_sum1;
    logic [16:0] w_e0;
    logic [16:0] w_e1;
    logic        w_peak;
    logic        w_boundary;
    logic [15:0] w_miss_inc;
    logic [15:0] w_det_mod;

    // Expected peak phases. The latched offset is always below WAVELENGTH,
    // so each 17-bit sum is below 2*WAVELENGTH and one conditional subtract
    // is an exact modulo. Phases >= WAVELENGTH can therefore never match.
    always_comb begin
        w_sum0     = {1'b0, r_offset} + c_QTR;
        w_sum1     = {1'b0, r_offset} + c_THREE_QTR;
        w_e0       = (w_sum0 >= c_WAVE17) ? (w_sum0 - c_WAVE17) : w_sum0;
        w_e1       = (w_sum1 >= c_WAVE17) ? (w_sum1 - c_WAVE17) : w_sum1;
        w_peak     = (({1'b0, phase} == w_e0) || ({1'b0, phase} == w_e1)) &&
                     (32'(signal) > c_THRESH);
        w_boundary = (phase == r_offset);
        w_miss_inc = r_miss + 16'd1;
        w_det_mod  = det_offset % c_WAVE16;
    end

    // Next-state and next-output decode; enable low overrides every state.
    always_comb begin
        w_state_nxt     = r_state;
        w_det_clear_nxt = r_det_clear;
        w_offset_nxt    = r_offset;
        w_locked_nxt    = r_locked;
        w_relock_nxt    = r_relock;
        w_acq_to_nxt    = 1'b0;
        w_timer_nxt     = r_timer;
        w_holdoff_nxt   = r_holdoff;
        w_miss_nxt      = r_miss;
        w_hit_nxt       = r_hit;

        if (!enable) begin
            w_state_nxt     = S_IDLE;
            w_locked_nxt    = 1'b0;
            w_det_clear_nxt = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt     = S_ACQUIRE;
                    w_det_clear_nxt = 1'b0;
                    w_timer_nxt     = 16'd0;
                end

                S_ACQUIRE: begin
                    w_timer_nxt     = r_timer + 16'd1;
                    w_det_clear_nxt = 1'b0;
                    // A detector result beats a simultaneous timer expiry.
                    if (det_ready) begin
                        w_offset_nxt = w_det_mod;
                        w_locked_nxt = 1'b1;
                        w_miss_nxt   = 16'd0;
                        w_hit_nxt    = 1'b0;
                        w_state_nxt  = S_LOCKED;
                    end else if (r_timer == c_ACQ_LAST) begin
                        w_acq_to_nxt    = 1'b1;
                        w_det_clear_nxt = 1'b1;
                        w_timer_nxt     = 16'd0;
                    end
                end

                S_LOCKED: begin
                    if (w_boundary) begin
                        w_hit_nxt = 1'b0;
                        if (r_hit || w_peak) begin
                            w_miss_nxt = 16'd0;
                        end else begin
                            w_miss_nxt = w_miss_inc;
                            if (w_miss_inc == c_MISS_LIMIT) begin
                                w_locked_nxt    = 1'b0;
                                w_det_clear_nxt = 1'b1;
                                w_relock_nxt    = (r_relock == 8'hFF) ? r_relock
                                                                      : r_relock + 8'd1;
                                w_holdoff_nxt   = 16'd0;
                                w_state_nxt     = S_HOLDOFF;
                            end
                        end
                    end else if (w_peak) begin
                        w_hit_nxt = 1'b1;
                    end
                end

                S_HOLDOFF: begin
                    w_det_clear_nxt = 1'b1;
                    w_locked_nxt    = 1'b0;
                    w_holdoff_nxt   = r_holdoff + 16'd1;
                    if (r_holdoff == c_HOLD_LAST) begin
                        w_state_nxt     = S_ACQUIRE;
                        w_det_clear_nxt = 1'b0;
                        w_timer_nxt     = 16'd0;
                    end
                end

                default: begin
                    w_state_nxt     = S_IDLE;
                    w_det_clear_nxt = 1'b1;
                    w_locked_nxt    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset clears any pending pulse at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_det_clear <= 1'b1;
            r_offset    <= 16'd0;
            r_locked    <= 1'b0;
            r_relock    <= 8'd0;
            r_acq_to    <= 1'b0;
            r_timer     <= 16'd0;
            r_holdoff   <= 16'd0;
            r_miss      <= 16'd0;
            r_hit       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_det_clear <= w_det_clear_nxt;
            r_offset    <= w_offset_nxt;
            r_locked    <= w_locked_nxt;
            r_relock    <= w_relock_nxt;
            r_acq_to    <= w_acq_to_nxt;
            r_timer     <= w_timer_nxt;
            r_holdoff   <= w_holdoff_nxt;
            r_miss      <= w_miss_nxt;
            r_hit       <= w_hit_nxt;
        end
    end

`ifdef CARRIER_SYNC_STATS_EN
    logic        w_miss_evt;
    logic [15:0] r_miss_total;

    assign w_miss_evt = enable && (r_state == S_LOCKED) && w_boundary &&
                        !(r_hit || w_peak);

    // Lifetime count of missed period boundaries, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_miss_total <= 16'd0;
        end else if (w_miss_evt && (r_miss_total != 16'hFFFF)) begin
            r_miss_total <= r_miss_total + 16'd1;
        end
    end

    assign miss_total = r_miss_total;
`endif

    assign det_clear    = r_det_clear;
    assign offset       = r_offset;
    assign locked       = r_locked;
    assign state        = r_state;
    assign relock_count = r_relock;
    assign acq_timeout  = r_acq_to;

endmodule
`default_nettype wire

// File: tb/tb_carrier_sync_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_carrier_sync_controller
// Description : Directed self-checking bench for carrier_sync_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_carrier_sync_controller;

    localparam int c_WAVE = 40;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [7:0]  signal;
    logic [15:0] phase;
    logic        det_ready;
    logic [15:0] det_offset;
    logic        det_clear;
    logic [15:0] offset;
    logic        locked;
    logic [1:0]  state;
    logic [7:0]  relock_count;
    logic        acq_timeout;
`ifdef CARRIER_SYNC_STATS_EN
    logic [15:0] miss_total;
`endif

    int n_checks;
    int n_pass;
    int n_fail;
    int mode;

    carrier_sync_controller dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .signal       (signal),
        .phase        (phase),
        .det_ready    (det_ready),
        .det_offset   (det_offset),
        .det_clear    (det_clear),
        .offset       (offset),
        .locked       (locked),
        .state        (state),
        .relock_count (relock_count),
        .acq_timeout  (acq_timeout)
`ifdef CARRIER_SYNC_STATS_EN
        ,
        .miss_total   (miss_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Received sample pattern: 0 = silent, 1 = peaks at phases 0 and 20,
    // 2 = peak only at phase 20 (flipped polarity).
    function automatic logic [7:0] sig_for(input logic [15:0] p);
        case (mode)
            1:       return ((p == 16'd0) || (p == 16'd20)) ? 8'd200 : 8'd0;
            2:       return (p == 16'd20) ? 8'd200 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    // One clock; afterwards outputs are sampled and the next phase/sample driven.
    task automatic tick();
        @(posedge clk);
        #1;
        phase  = (phase == 16'(c_WAVE - 1)) ? 16'd0 : phase + 16'd1;
        signal = sig_for(phase);
    endtask

    initial begin
        int bad;
        int bcount;
        int lost;
        int last_b;
        int cnt;
        int np;
        int p1;
        int p2;
        int dc_bad;
        int st_bad;

        n_checks = 0; n_pass = 0; n_fail = 0; mode = 0;
        rst = 1'b1; enable = 1'b0; det_ready = 1'b0; det_offset = 16'd0;
        phase = 16'd0; signal = 8'd0;

        tick(); tick();
        check("rst_state",   32'(state), 32'd0);
        check("rst_clear",   32'(det_clear), 32'd1);
        check("rst_offset",  32'(offset), 32'd0);
        check("rst_locked",  32'(locked), 32'd0);
        check("rst_relock",  32'(relock_count), 32'd0);
        check("rst_acqto",   32'(acq_timeout), 32'd0);

        rst = 1'b0;
        tick();
        check("idle_hold", 32'(state), 32'd0);

        // Acquisition with a result 20 cycles in
        enable = 1'b1;
        tick();
        check("acq_state", 32'(state), 32'd1);
        check("acq_clear", 32'(det_clear), 32'd0);
        repeat (18) tick();
        check("acq_wait", 32'(state), 32'd1);
        det_ready = 1'b1; det_offset = 16'd30;
        tick();
        det_ready = 1'b0; det_offset = 16'd0;
        check("lock_state",  32'(state), 32'd2);
        check("lock_offset", 32'(offset), 32'd30);
        check("lock_locked", 32'(locked), 32'd1);
        check("lock_clear",  32'(det_clear), 32'd0);

        // Tracking: both polarities, then single polarity
        mode = 1; bad = 0;
        repeat (2000) begin
            tick();
            if (locked !== 1'b1 || state !== 2'd2) bad++;
        end
        check("track_dual", 32'(bad), 32'd0);
        mode = 2; bad = 0;
        repeat (800) begin
            tick();
            if (locked !== 1'b1 || state !== 2'd2) bad++;
        end
        check("track_flip", 32'(bad), 32'd0);

        // Loss of lock: go silent right after a boundary (phase 30)
        for (int i = 0; i < 40; i++) begin
            if (phase == 16'd31) break;
            tick();
        end
        mode = 0; bcount = 0; lost = 0; last_b = 0;
        for (int i = 0; i < 200; i++) begin
            last_b = (phase == 16'd30) ? 1 : 0;
            if (last_b == 1) bcount++;
            tick();
            if (locked == 1'b0) begin
                lost = 1;
                break;
            end
        end
        check("loss_seen",    32'(lost), 32'd1);
        check("loss_bounds",  32'(bcount), 32'd3);
        check("loss_at_bnd",  32'(last_b), 32'd1);
        check("loss_state",   32'(state), 32'd3);
        check("loss_relock",  32'(relock_count), 32'd1);
        check("loss_clear",   32'(det_clear), 32'd1);
        check("loss_offset",  32'(offset), 32'd30);

        // Holdoff length
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (state != 2'd3) break;
            if (det_clear == 1'b1) cnt++;
            tick();
        end
        check("hold_len",   32'(cnt), 32'd8);
        check("hold_exit",  32'(state), 32'd1);
        check("hold_clear", 32'(det_clear), 32'd0);

        // Acquisition timeouts: fresh attempt, timer = 0 at this sample
        np = 0; p1 = -1; p2 = -1; dc_bad = 0; st_bad = 0;
        for (int k = 1; k <= 250; k++) begin
            tick();
            if (acq_timeout == 1'b1) begin
                np++;
                if (np == 1) p1 = k;
                if (np == 2) p2 = k;
            end
            if (det_clear !== acq_timeout) dc_bad++;
            if (state !== 2'd1) st_bad++;
        end
        check("to_count",  32'(np), 32'd2);
        check("to_first",  32'(p1), 32'd100);
        check("to_second", 32'(p2), 32'd200);
        check("to_clear",  32'(dc_bad), 32'd0);
        check("to_state",  32'(st_bad), 32'd0);

        // det_ready coincident with timer == ACQ_TIMEOUT-1
        repeat (49) tick();
        det_ready = 1'b1; det_offset = 16'd75;
        tick();
        det_ready = 1'b0; det_offset = 16'd0;
        check("coin_state",  32'(state), 32'd2);
        check("coin_acqto",  32'(acq_timeout), 32'd0);
        check("coin_offset", 32'(offset), 32'd35);
        check("coin_locked", 32'(locked), 32'd1);

        // Second loss, then drop enable in HOLDOFF
        for (int i = 0; i < 300; i++) begin
            if (state == 2'd3) break;
            tick();
        end
        check("loss2_state",  32'(state), 32'd3);
        check("loss2_relock", 32'(relock_count), 32'd2);
        enable = 1'b0;
        tick();
        check("dis_state",  32'(state), 32'd0);
        check("dis_offset", 32'(offset), 32'd35);
        check("dis_locked", 32'(locked), 32'd0);
        check("dis_clear",  32'(det_clear), 32'd1);
        check("dis_relock", 32'(relock_count), 32'd2);

        // Asynchronous reset while locked
        enable = 1'b1;
        tick();
        det_ready = 1'b1; det_offset = 16'd10;
        tick();
        det_ready = 1'b0; det_offset = 16'd0;
        check("pre_rst_state",  32'(state), 32'd2);
        check("pre_rst_offset", 32'(offset), 32'd10);
        #2 rst = 1'b1;
        #1;
        check("arst_state",  32'(state), 32'd0);
        check("arst_offset", 32'(offset), 32'd0);
        check("arst_locked", 32'(locked), 32'd0);
        check("arst_relock", 32'(relock_count), 32'd0);
        check("arst_clear",  32'(det_clear), 32'd1);
        check("arst_acqto",  32'(acq_timeout), 32'd0);
        tick();
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
